alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter: ALU_LAT, default 1, cycles operands are held to the external ALU before writeback (legal 1..3).
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: instr_valid  input  1  instruction offered.
REQ-005 SHALL have port: instr_ready  output  1  sequencer can accept an instruction.
REQ-006 SHALL have port: instr  input  9  {op[8:6], rd[5:4], ra[3:2], rb[1:0]}.
REQ-007 SHALL have port: ld_en  input  1  host register load strobe.
REQ-008 SHALL have port: ld_addr  input  2  host load target register.
REQ-009 SHALL have port: ld_data  input  4  host load value.
REQ-010 SHALL have port: rd_addr  input  2  readback address.
REQ-011 SHALL have port: rd_data  output  4  combinational R[rd_addr].
REQ-012 SHALL have port: alu_a, alu_b  output  4 each  operands to the ALU.
REQ-013 SHALL have port: alu_sel  output  3  ALU opcode (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 shl, 111 shr).
REQ-014 SHALL have port: alu_out  input  4 and carry_in_alu  input  1  ALU result and carry.
REQ-015 SHALL have port: done  output  1  one-cycle writeback pulse.
REQ-016 SHALL have port: carry_flag  output  1  carry from last writeback.

Function
REQ-017 SHALL contain 4x4-bit register file R0..R3.
REQ-018 SHALL implement FSM IDLE -> EXEC -> WB -> IDLE; instr_ready = 1 only in IDLE.
REQ-019 SHALL accept on clk edge with instr_valid & instr_ready; at acceptance register alu_a=R[ra], alu_b=R[rb], alu_sel=op, latch rd, enter EXEC.
REQ-020 SHALL stay in EXEC exactly ALU_LAT cycles (down-counter), then enter WB.
REQ-021 SHALL in WB write R[rd]=alu_out, carry_flag=carry_in_alu, assert done for that cycle, return to IDLE.
REQ-022 SHALL give latency: accept at edge T, done high in cycle T+ALU_LAT+1, ready again at T+ALU_LAT+2.
REQ-023 SHALL hold alu_a/alu_b/alu_sel stable from acceptance until the next acceptance.
REQ-024 SHALL snapshot operands at acceptance, so rd equal to ra or rb is legal and reads old value.
REQ-025 SHALL honour ld_en only in IDLE; in IDLE with simultaneous acceptance, load is written first-cycle and operand snapshot uses pre-load value; ld_en in EXEC/WB is ignored.
REQ-026 SHALL leave carry_flag unchanged except in WB.

Reset
REQ-027 SHALL on rst=1 at an edge: state IDLE, R0..R3=0, alu_a=alu_b=0, alu_sel=000, carry_flag=0, done=0, counter=0.
REQ-028 SHALL abort any in-flight instruction on reset with no writeback and no done pulse; rst dominates instr_valid and ld_en.

Configuration
REQ-029 SHALL support macro ALU_SEQ_ZERO_FLAG_EN: when defined, add output zero_flag (1 bit), reset 0, set in WB to (alu_out==0), else held.
REQ-030 SHALL, without ALU_SEQ_ZERO_FLAG_EN, have no zero_flag port and no associated logic.

Verification
REQ-031 SHALL verify: ld R0=5, R1=3; instr op=000 rd=2 ra=0 rb=1, ALU model add -> alu_a=5, alu_b=3, done at T+2, R2=8, carry_flag=0.
REQ-032 SHALL verify: R0=F, R1=1, add into R3 -> R3=0, carry_flag=1; zero_flag=1 when macro defined.
REQ-033 SHALL verify: instr_valid held high with ALU_LAT=1 -> acceptance every 3 cycles, instr_ready low in EXEC/WB.
REQ-034 SHALL verify: rst asserted during EXEC -> next cycle IDLE, all registers 0, no done pulse.
REQ-035 SHALL verify: ld_en R1=7 during EXEC -> ignored, R1 unchanged; ALU_LAT=3 -> done at T+4.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Sequences one instruction at a time through an external ALU: snapshot operands, wait ALU_LAT cycles, write back.
// Optional zero_flag output is enabled by defining ALU_SEQ_ZERO_FLAG_EN.
module alu_op_sequencer #(
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [8:0] instr,
  input  logic       ld_en,
  input  logic [1:0] ld_addr,
  input  logic [3:0] ld_data,
  input  logic [1:0] rd_addr,
  output logic [3:0] rd_data,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [3:0] alu_out,
  input  logic       carry_in_alu,
  output logic       done,
  output logic       carry_flag
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic       zero_flag
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  regs_q [4];
  logic [3:0]  regs_d [4];
  logic [3:0]  alu_a_q, alu_a_d;
  logic [3:0]  alu_b_q, alu_b_d;
  logic [2:0]  alu_sel_q, alu_sel_d;
  logic [1:0]  rd_q, rd_d;
  logic        carry_q, carry_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic        zero_q, zero_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    regs_d    = regs_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    rd_d      = rd_q;
    carry_d   = carry_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    zero_d    = zero_q;
`endif
    case (state_q)
      IDLE: begin
        // Operands come from regs_q, so a same-cycle host load is not seen by the snapshot.
        if (ld_en) regs_d[ld_addr] = ld_data;
        if (instr_valid) begin
          alu_sel_d = instr[8:6];
          rd_d      = instr[5:4];
          alu_a_d   = regs_q[instr[3:2]];
          alu_b_d   = regs_q[instr[1:0]];
          cnt_d     = 2'(ALU_LAT - 1);
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 2'd0) state_d = WB;
        else               cnt_d   = cnt_q - 2'd1;
      end
      WB: begin
        regs_d[rd_q] = alu_out;
        carry_d      = carry_in_alu;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        zero_d       = (alu_out == 4'd0);
`endif
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      regs_q    <= '{default: 4'd0};
      alu_a_q   <= 4'd0;
      alu_b_q   <= 4'd0;
      alu_sel_q <= 3'd0;
      rd_q      <= 2'd0;
      carry_q   <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      regs_q    <= regs_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      rd_q      <= rd_d;
      carry_q   <= carry_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero_q    <= zero_d;
`endif
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign done        = (state_q == WB);
  assign rd_data     = regs_q[rd_addr];
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_sel     = alu_sel_q;
  assign carry_flag  = carry_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  assign zero_flag   = zero_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: one instance with ALU_LAT=1, one with ALU_LAT=3.
module tb_alu_op_sequencer;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic       c;
    logic       z;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
    case (sel)
      3'b000: alu_f = {1'b0, a} + {1'b0, b};
      3'b001: alu_f = {1'b0, a} - {1'b0, b};
      3'b010: alu_f = {1'b0, a & b};
      3'b011: alu_f = {1'b0, a | b};
      3'b100: alu_f = {1'b0, a ^ b};
      3'b101: alu_f = {1'b0, ~a};
      3'b110: alu_f = {a, 1'b0};
      default: alu_f = {a[0], 1'b0, a[3:1]};
    endcase
  endfunction

  // ---------------- instance with ALU_LAT = 1 ----------------
  logic       rst = 1'b1, instr_valid = 1'b0, ld_en = 1'b0;
  logic [8:0] instr = '0;
  logic [1:0] ld_addr = '0, rd_addr = '0;
  logic [3:0] ld_data = '0;
  logic       instr_ready, done, carry_flag, carry_in_alu;
  logic [3:0] rd_data, alu_a, alu_b, alu_out;
  logic [2:0] alu_sel;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic       zero_flag;
`endif
  assign {carry_in_alu, alu_out} = alu_f(alu_a, alu_b, alu_sel);

  alu_op_sequencer #(.ALU_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .carry_in_alu(carry_in_alu), .done(done), .carry_flag(carry_flag)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , .zero_flag(zero_flag)
`endif
  );

  // ---------------- instance with ALU_LAT = 3 ----------------
  logic       rst3 = 1'b1, instr_valid3 = 1'b0, ld_en3 = 1'b0;
  logic [8:0] instr3 = '0;
  logic [1:0] ld_addr3 = '0, rd_addr3 = '0;
  logic [3:0] ld_data3 = '0;
  logic       instr_ready3, done3, carry_flag3, carry_in_alu3;
  logic [3:0] rd_data3, alu_a3, alu_b3, alu_out3;
  logic [2:0] alu_sel3;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic       zero_flag3;
`endif
  assign {carry_in_alu3, alu_out3} = alu_f(alu_a3, alu_b3, alu_sel3);

  alu_op_sequencer #(.ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst3), .instr_valid(instr_valid3), .instr_ready(instr_ready3), .instr(instr3),
    .ld_en(ld_en3), .ld_addr(ld_addr3), .ld_data(ld_data3), .rd_addr(rd_addr3), .rd_data(rd_data3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3), .alu_out(alu_out3),
    .carry_in_alu(carry_in_alu3), .done(done3), .carry_flag(carry_flag3)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , .zero_flag(zero_flag3)
`endif
  );

  // ---------------- scoreboards and monitors ----------------
  exp_t q1[$];
  exp_t q3[$];
  exp_t cur1, cur3;
  bit   pend1 = 1'b0, pend3 = 1'b0;

  always @(negedge clk) begin
    if (pend1) begin
      pend1 = 1'b0;
      chk("carry_flag_after_wb", 32'(carry_flag), 32'(cur1.c));
`ifdef ALU_SEQ_ZERO_FLAG_EN
      chk("zero_flag_after_wb", 32'(zero_flag), 32'(cur1.z));
`endif
    end
    if (done) begin
      if (q1.size() == 0) chk("unexpected_done", 32'(1), 32'(0));
      else begin
        cur1 = q1.pop_front();
        chk("alu_a", 32'(alu_a), 32'(cur1.a));
        chk("alu_b", 32'(alu_b), 32'(cur1.b));
        chk("alu_sel", 32'(alu_sel), 32'(cur1.sel));
        chk("done_cycle", 32'(cyc), 32'(cur1.cyc));
        pend1 = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (pend3) begin
      pend3 = 1'b0;
      chk("lat3_carry_flag", 32'(carry_flag3), 32'(cur3.c));
    end
    if (done3) begin
      if (q3.size() == 0) chk("lat3_unexpected_done", 32'(1), 32'(0));
      else begin
        cur3 = q3.pop_front();
        chk("lat3_alu_a", 32'(alu_a3), 32'(cur3.a));
        chk("lat3_alu_b", 32'(alu_b3), 32'(cur3.b));
        chk("lat3_alu_sel", 32'(alu_sel3), 32'(cur3.sel));
        chk("lat3_done_cycle", 32'(cyc), 32'(cur3.cyc));
        pend3 = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers (instance 1) ----------------
  task automatic load(input logic [1:0] a, input logic [3:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [1:0] a, input logic [3:0] req);
    @(negedge clk);
    rd_addr = a;
    #1 chk(name, 32'(rd_data), 32'(req));
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) chk("ready_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q1.size() != 0 || pend1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q1.size() != 0) chk("drain_timeout", 32'(q1.size()), 32'(0));
  endtask

  // Returns #1 after the accepting edge, with the sequencer in EXEC.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input logic [3:0] ea, input logic [3:0] eb,
                       input logic ec, input logic ez, input bit push,
                       input bit ld, input logic [1:0] la, input logic [3:0] lv);
    exp_t e;
    wait_ready();
    instr = {op, rd, ra, rb};
    instr_valid = 1'b1;
    ld_en = ld; ld_addr = la; ld_data = lv;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    ld_en = 1'b0;
    e.a = ea; e.b = eb; e.sel = op; e.c = ec; e.z = ez; e.cyc = cyc + 1;
    if (push) q1.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  logic [8:0] b2b_instr [3];
  exp_t       b2b_exp [3];

  initial begin
    exp_t e;
    int   t0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; rst3 = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'(1));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_alu_a", 32'(alu_a), 32'(0));
    chk("rst_alu_b", 32'(alu_b), 32'(0));
    chk("rst_alu_sel", 32'(alu_sel), 32'(0));
    chk("rst_carry", 32'(carry_flag), 32'(0));
    for (int i = 0; i < 4; i++) read_chk("rst_reg", 2'(i), 4'h0);

    // basic add: 5 + 3 -> R2 = 8
    load(2'd0, 4'h5);
    load(2'd1, 4'h3);
    issue(3'b000, 2'd2, 2'd0, 2'd1, 4'h5, 4'h3, 1'b0, 1'b0, 1, 0, 2'd0, 4'h0);
    wait_drain();
    read_chk("add_R2", 2'd2, 4'h8);

    // add with carry out: F + 1 -> R3 = 0, carry 1
    load(2'd0, 4'hF);
    load(2'd1, 4'h1);
    issue(3'b000, 2'd3, 2'd0, 2'd1, 4'hF, 4'h1, 1'b1, 1'b1, 1, 0, 2'd0, 4'h0);
    wait_drain();
    read_chk("carry_R3", 2'd3, 4'h0);

    // carry held outside writeback; rd == ra reads old value: R0 = F - 1 = E
    @(negedge clk);
    chk("carry_held", 32'(carry_flag), 32'(1));
    issue(3'b001, 2'd0, 2'd0, 2'd1, 4'hF, 4'h1, 1'b0, 1'b0, 1, 0, 2'd0, 4'h0);
    wait_drain();
    read_chk("rd_eq_ra_R0", 2'd0, 4'hE);

    // load R1=2 together with acceptance: snapshot uses old R1=1; 1 ^ E = F
    issue(3'b100, 2'd2, 2'd1, 2'd0, 4'h1, 4'hE, 1'b0, 1'b0, 1, 1, 2'd1, 4'h2);
    wait_drain();
    read_chk("ld_accept_R1", 2'd1, 4'h2);
    read_chk("ld_accept_R2", 2'd2, 4'hF);

    // load during EXEC/WB ignored: R3 = 2 | 2
    issue(3'b011, 2'd3, 2'd1, 2'd1, 4'h2, 4'h2, 1'b0, 1'b0, 1, 0, 2'd0, 4'h0);
    ld_en = 1'b1; ld_addr = 2'd1; ld_data = 4'h7;
    @(posedge clk);
    @(posedge clk);
    #1 ld_en = 1'b0;
    wait_drain();
    read_chk("ld_exec_ignored_R1", 2'd1, 4'h2);
    read_chk("or_R3", 2'd3, 4'h2);

    // back-to-back with instr_valid held high: R = {E, 2, F, 2}
    b2b_instr[0] = {3'b110, 2'd0, 2'd2, 2'd0};
    b2b_instr[1] = {3'b101, 2'd1, 2'd2, 2'd3};
    b2b_instr[2] = {3'b001, 2'd2, 2'd3, 2'd2};
    b2b_exp[0] = '{a: 4'hF, b: 4'hE, sel: 3'b110, c: 1'b1, z: 1'b0, cyc: 0};
    b2b_exp[1] = '{a: 4'hF, b: 4'h2, sel: 3'b101, c: 1'b0, z: 1'b1, cyc: 0};
    b2b_exp[2] = '{a: 4'h2, b: 4'hF, sel: 3'b001, c: 1'b1, z: 1'b0, cyc: 0};
    wait_ready();
    instr = b2b_instr[0];
    instr_valid = 1'b1;
    t0 = -1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (t0 < 0) t0 = cyc;
      e = b2b_exp[k];
      e.cyc = t0 + 3 * k + 1;
      q1.push_back(e);
      if (k < 2) instr = b2b_instr[k + 1];
      chk("b2b_ready_exec", 32'(instr_ready), 32'(0));
      @(posedge clk);
      #1 chk("b2b_ready_wb", 32'(instr_ready), 32'(0));
      @(posedge clk);
      #1 chk("b2b_ready_idle", 32'(instr_ready), 32'(1));
      if (k == 2) instr_valid = 1'b0;
    end
    wait_drain();
    read_chk("b2b_R0", 2'd0, 4'hE);
    read_chk("b2b_R1", 2'd1, 4'h0);
    read_chk("b2b_R2", 2'd2, 4'h3);
    read_chk("b2b_R3", 2'd3, 4'h2);

    // reset during EXEC aborts with no writeback and no done
    issue(3'b010, 2'd0, 2'd1, 2'd2, 4'h0, 4'h3, 1'b0, 1'b0, 0, 0, 2'd0, 4'h0);
    rst = 1'b1;
    instr_valid = 1'b1;
    ld_en = 1'b1; ld_addr = 2'd3; ld_data = 4'h9;
    @(posedge clk);
    #1 rst = 1'b0; instr_valid = 1'b0; ld_en = 1'b0;
    chk("abort_ready", 32'(instr_ready), 32'(1));
    chk("abort_alu_a", 32'(alu_a), 32'(0));
    chk("abort_alu_b", 32'(alu_b), 32'(0));
    chk("abort_carry", 32'(carry_flag), 32'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'(0));
    end
    for (int i = 0; i < 4; i++) read_chk("abort_reg", 2'(i), 4'h0);

    // ALU_LAT = 3 instance: done three cycles after acceptance, load during EXEC ignored
    @(negedge clk);
    ld_en3 = 1'b1; ld_addr3 = 2'd0; ld_data3 = 4'h4;
    @(negedge clk);
    ld_addr3 = 2'd1; ld_data3 = 4'h9;
    @(negedge clk);
    ld_en3 = 1'b0;
    chk("lat3_ready", 32'(instr_ready3), 32'(1));
    instr3 = {3'b000, 2'd2, 2'd0, 2'd1};
    instr_valid3 = 1'b1;
    @(posedge clk);
    #1;
    instr_valid3 = 1'b0;
    e = '{a: 4'h4, b: 4'h9, sel: 3'b000, c: 1'b0, z: 1'b0, cyc: cyc + 3};
    q3.push_back(e);
    ld_en3 = 1'b1; ld_addr3 = 2'd1; ld_data3 = 4'h7;
    chk("lat3_ready_exec", 32'(instr_ready3), 32'(0));
    repeat (4) @(posedge clk);
    #1 ld_en3 = 1'b0;
    chk("lat3_ready_again", 32'(instr_ready3), 32'(1));
    repeat (2) @(negedge clk);
    rd_addr3 = 2'd1;
    #1 chk("lat3_R1_unchanged", 32'(rd_data3), 32'(4'h9));
    rd_addr3 = 2'd2;
    #1 chk("lat3_R2_sum", 32'(rd_data3), 32'(4'hD));

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(q1.size() + q3.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
